vgalcd_tmg_gen: RTL and testbench
=================================

# vgalcd_tmg_gen

Programmable, parametrised display timing generator and pixel sequencer for the vgalcd subsystem. It sits between the pixel FIFO fed by the AXI4 framebuffer reader and the VGA/LCD pins, and it takes its register values from the APB4 register block. Features:
- Per-segment horizontal and vertical timing.
- Selectable sync polarity.
- Integer pixel-clock divider.
- Frame-boundary shadowing of the configuration.
- Pixel-underrun detection with a saturating counter.

## Interface
Parameters:
- CNT_WIDTH, 12, width of every timing field and segment counter.
- DATA_WIDTH, 24, pixel width (RGB888 default).
- DIV_WIDTH, 8, width of the pixel clock divider.
- UCNT_WIDTH, 16, width of the underrun counter.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  generator enable.
- div_i  in  DIV_WIDTH  pixel tick every div_i+1 clocks.
- hsync_i, hbp_i, hact_i, hfp_i  in  CNT_WIDTH each  horizontal segment length minus 1, in pixels.
- vsync_i, vbp_i, vact_i, vfp_i  in  CNT_WIDTH each  vertical segment length minus 1, in lines.
- hpol_i, vpol_i  in  1 each  1 = sync active-low, 0 = active-high.
- pix_valid_i  in  1  FIFO has a pixel.
- pix_data_i  in  DATA_WIDTH  pixel from the FIFO.
- pix_ready_o  out  1  pixel consumed this cycle.
- pclk_en_o  out  1  one-clock pixel tick.
- hsync_o, vsync_o  out  1 each  sync outputs.
- de_o  out  1  data enable.
- rgb_o  out  DATA_WIDTH  pixel out.
- frame_start_o  out  1  one-clock pulse at the first pixel of each frame.
- underrun_o  out  1  one-clock pulse per missed pixel.
- underrun_cnt_o  out  UCNT_WIDTH  saturating underrun count.

## Operation
- Divider:
  - divcnt is held at 0 while en_i=0.
  - tick = en_i & (divcnt==0).
  - divcnt increments each clock and wraps to 0 after reaching the shadowed div.
  - pclk_en_o = tick (combinational).
- Horizontal FSM, advancing on tick: H_SYNC -> H_BP -> H_ACT -> H_FP -> H_SYNC.
  - Each state loads a down-counter with its field value and leaves when the counter is 0.
  - Segment length is field+1.
- Vertical FSM: V_SYNC -> V_BP -> V_ACT -> V_FP -> V_SYNC, with the same rule.
  - It advances only on the tick that ends H_FP.
- Line length = sum of the four (h field+1). Frame length = sum of the four (v field+1) lines.
- Shadowing: all config inputs are sampled on the first tick after enable and on every frame-boundary tick. The frame-boundary tick is the end of the last H_FP of the last V_FP line. Between those ticks, input changes are ignored.
- Disabled (en_i=0):
  - FSMs return to H_SYNC/V_SYNC with counters cleared on the next clock.
  - Registered outputs go to their idle values: de_o=0, rgb_o=0, sync outputs = inactive level of the shadowed polarity.
  - Disabling mid-frame aborts the frame immediately. Re-enabling always starts a fresh frame.
- Registered outputs update only on tick edges, reflecting the pixel period that begins at that edge:
  - hsync_o = (H_SYNC) ^ hpol.
  - vsync_o = (V_SYNC) ^ vpol.
  - de_o = H_ACT & V_ACT.
- Pixel handshake:
  - pix_ready_o = tick & next_state_is_active & pix_valid_i.
  - When it is high, rgb_o <= pix_data_i.
  - If the next period is active and pix_valid_i=0, then rgb_o <= 0, de_o stays 1, underrun_o pulses for that clock, and underrun_cnt_o increments, saturating at all-ones.
  - During blanking rgb_o <= 0 and no pixel is consumed.
- underrun_cnt_o clears on the clock where en_i rises from 0 to 1.

## Timing
- Reset values: every output is 0, FSMs are in H_SYNC/V_SYNC, and shadow registers are 0 (active-high polarity, so the inactive sync level is 0).
- Enable: tick occurs in the first clock with en_i=1. At that edge the outputs present frame pixel 0 and frame_start_o=1.
- Latency from tick to outputs: 1 clock, because outputs are registered at the tick edge.
- pix_ready_o and underrun_o are 1-clock pulses. There is at most one of them per tick, and never both in the same clock.
- div=0 gives a tick every clock. div=N gives a tick every N+1 clocks.
- Minimum segment length is 1 tick (field=0). All-zero fields give a 4-tick line and a 4-line frame.
- en_i is sampled every clock. A disable takes precedence over a simultaneous tick.

## Test plan
- Basic frame:
  - Stimulus: h fields 1,0,3,0; v fields 0,0,1,0; div=0; pol=0; FIFO always valid with an incrementing pattern.
  - Required: 8-clock lines and a 40-clock frame. hsync_o is high 2 clocks per line and vsync_o is high 8 clocks per frame. de_o is high 4 clocks on each of lines 2-3. 8 pixels are consumed in order. frame_start_o pulses every 40 clocks.
- Divider and polarity:
  - Stimulus: the same timing with div=2 and hpol=vpol=1.
  - Required: pclk_en_o fires every 3 clocks, the line is 24 clocks long, and sync is active-low (idle level 1 after the first frame boundary).
- Underrun:
  - Stimulus: drop pix_valid_i for 3 active pixels.
  - Required: 3 underrun_o pulses, rgb_o=0 on those pixels, de_o stays 1, and underrun_cnt_o=3. The counter saturates at 0xFFFF under continuous underrun.
- Shadowing:
  - Stimulus: change hact_i from 3 to 7 mid-frame.
  - Required: the current frame keeps the 8-clock line and the next frame uses a 12-clock line.
- Disable mid-frame:
  - Stimulus: drop en_i in line 3, then re-enable.
  - Required: outputs idle the next clock. On re-enable, frame_start_o fires in the first clock and underrun_cnt_o is cleared.
- Reset:
  - Stimulus: assert rst_n_i asynchronously mid-active.
  - Required: all outputs are 0 immediately. Operation resumes from frame start after release with en_i=1.

Source files
------------

// File: rtl/vgalcd_tmg_gen.sv
// -----------------------------------------------------------------------------
// vgalcd_tmg_gen
//
// Programmable display timing generator and pixel sequencer. Produces the
// pixel tick, sync/data-enable timing, and drains the pixel FIFO during the
// active area. The timing configuration is shadowed so that it changes only
// at frame boundaries.
//
// Ports
//   clk_i            system clock
//   rst_n_i          asynchronous active-low reset
//   en_i             generator enable
//   div_i            pixel tick every div_i+1 clocks
//   hsync_i..hfp_i   horizontal segment lengths minus 1 (pixels)
//   vsync_i..vfp_i   vertical segment lengths minus 1 (lines)
//   hpol_i, vpol_i   1 = sync active-low, 0 = active-high
//   pix_valid_i      FIFO has a pixel
//   pix_data_i       pixel from the FIFO
//   pix_ready_o      pixel consumed this clock
//   pclk_en_o        one-clock pixel tick
//   hsync_o, vsync_o sync outputs
//   de_o             data enable
//   rgb_o            pixel out
//   frame_start_o    one-clock pulse with the first pixel of each frame
//   underrun_o       one-clock pulse per missed pixel
//   underrun_cnt_o   saturating underrun count
// -----------------------------------------------------------------------------
module vgalcd_tmg_gen #(
   parameter int CNT_WIDTH  = 12,
   parameter int DATA_WIDTH = 24,
   parameter int DIV_WIDTH  = 8,
   parameter int UCNT_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  en_i,
   input  logic [DIV_WIDTH-1:0]  div_i,
   input  logic [CNT_WIDTH-1:0]  hsync_i,
   input  logic [CNT_WIDTH-1:0]  hbp_i,
   input  logic [CNT_WIDTH-1:0]  hact_i,
   input  logic [CNT_WIDTH-1:0]  hfp_i,
   input  logic [CNT_WIDTH-1:0]  vsync_i,
   input  logic [CNT_WIDTH-1:0]  vbp_i,
   input  logic [CNT_WIDTH-1:0]  vact_i,
   input  logic [CNT_WIDTH-1:0]  vfp_i,
   input  logic                  hpol_i,
   input  logic                  vpol_i,
   input  logic                  pix_valid_i,
   input  logic [DATA_WIDTH-1:0] pix_data_i,
   output logic                  pix_ready_o,
   output logic                  pclk_en_o,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic                  de_o,
   output logic [DATA_WIDTH-1:0] rgb_o,
   output logic                  frame_start_o,
   output logic                  underrun_o,
   output logic [UCNT_WIDTH-1:0] underrun_cnt_o
);

   typedef enum logic [1:0] {
      H_SYNC = 2'd0,
      H_BP   = 2'd1,
      H_ACT  = 2'd2,
      H_FP   = 2'd3
   } h_state_t;

   typedef enum logic [1:0] {
      V_SYNC = 2'd0,
      V_BP   = 2'd1,
      V_ACT  = 2'd2,
      V_FP   = 2'd3
   } v_state_t;

   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = DIV_WIDTH'(1);
   localparam logic [UCNT_WIDTH-1:0] UCNT_ONE = UCNT_WIDTH'(1);

   // Saturating increment of the underrun counter.
   function automatic logic [UCNT_WIDTH-1:0] sat_inc(input logic [UCNT_WIDTH-1:0] v);
      if (&v) return v;
      return v + UCNT_ONE;
   endfunction

   // Field value for a segment index (SYNC, BP, ACT, FP).
   function automatic logic [CNT_WIDTH-1:0] seg_len(
      input logic [1:0]           sel,
      input logic [CNT_WIDTH-1:0] f_sync,
      input logic [CNT_WIDTH-1:0] f_bp,
      input logic [CNT_WIDTH-1:0] f_act,
      input logic [CNT_WIDTH-1:0] f_fp
   );
      case (sel)
         2'd0:    return f_sync;
         2'd1:    return f_bp;
         2'd2:    return f_act;
         default: return f_fp;
      endcase
   endfunction

   // Shadowed configuration
   logic [DIV_WIDTH-1:0] div_sh;
   logic [CNT_WIDTH-1:0] hsync_sh, hbp_sh, hact_sh, hfp_sh;
   logic [CNT_WIDTH-1:0] vsync_sh, vbp_sh, vact_sh, vfp_sh;
   logic                 hpol_sh, vpol_sh;

   // Effective configuration: raw inputs on a load tick, shadow otherwise
   logic [DIV_WIDTH-1:0] div_e;
   logic [CNT_WIDTH-1:0] hsync_e, hbp_e, hact_e, hfp_e;
   logic [CNT_WIDTH-1:0] vsync_e, vbp_e, vact_e, vfp_e;
   logic                 hpol_e, vpol_e;

   // Control state
   logic [DIV_WIDTH-1:0] divcnt_q, divcnt_nxt;
   logic                 run_q, run_nxt;
   logic                 en_q;
   h_state_t             h_st_q, h_nxt;
   v_state_t             v_st_q, v_nxt;
   logic [CNT_WIDTH-1:0] hcnt_q, hcnt_nxt;
   logic [CNT_WIDTH-1:0] vcnt_q, vcnt_nxt;
   logic [UCNT_WIDTH-1:0] ucnt_q;

   // Registered output stage
   logic                  hsync_p1, vsync_p1, de_p1, fs_p1;
   logic [DATA_WIDTH-1:0] rgb_p1;

   logic tick, frame_end, new_frame, load_cfg, nxt_act, under;

   // Gating with rst_n_i keeps every output at zero while reset is held,
   // including the combinational strobes.
   assign tick      = en_i & rst_n_i & (divcnt_q == '0);
   assign frame_end = (h_st_q == H_FP) & (hcnt_q == '0) &
                      (v_st_q == V_FP) & (vcnt_q == '0);
   // A tick either starts a fresh frame (first tick after enable, or the
   // tick ending the last pixel of the frame) or advances within one.
   assign new_frame = ~run_q | frame_end;
   assign load_cfg  = tick & new_frame;

   assign div_e   = load_cfg ? div_i   : div_sh;
   assign hsync_e = load_cfg ? hsync_i : hsync_sh;
   assign hbp_e   = load_cfg ? hbp_i   : hbp_sh;
   assign hact_e  = load_cfg ? hact_i  : hact_sh;
   assign hfp_e   = load_cfg ? hfp_i   : hfp_sh;
   assign vsync_e = load_cfg ? vsync_i : vsync_sh;
   assign vbp_e   = load_cfg ? vbp_i   : vbp_sh;
   assign vact_e  = load_cfg ? vact_i  : vact_sh;
   assign vfp_e   = load_cfg ? vfp_i   : vfp_sh;
   assign hpol_e  = load_cfg ? hpol_i  : hpol_sh;
   assign vpol_e  = load_cfg ? vpol_i  : vpol_sh;

   // Next-state logic for both timing FSMs and their segment counters
   always_comb begin
      h_nxt    = h_st_q;
      v_nxt    = v_st_q;
      hcnt_nxt = hcnt_q;
      vcnt_nxt = vcnt_q;
      run_nxt  = run_q;
      if (!en_i) begin
         h_nxt    = H_SYNC;
         v_nxt    = V_SYNC;
         hcnt_nxt = '0;
         vcnt_nxt = '0;
         run_nxt  = 1'b0;
      end else if (tick) begin
         run_nxt = 1'b1;
         if (new_frame) begin
            h_nxt    = H_SYNC;
            v_nxt    = V_SYNC;
            hcnt_nxt = hsync_e;
            vcnt_nxt = vsync_e;
         end else if (hcnt_q != '0) begin
            hcnt_nxt = hcnt_q - CNT_ONE;
         end else begin
            case (h_st_q)
               H_SYNC:  h_nxt = H_BP;
               H_BP:    h_nxt = H_ACT;
               H_ACT:   h_nxt = H_FP;
               default: h_nxt = H_SYNC;
            endcase
            hcnt_nxt = seg_len(h_nxt, hsync_e, hbp_e, hact_e, hfp_e);
            // The vertical FSM moves only when a line completes.
            if (h_st_q == H_FP) begin
               if (vcnt_q != '0) begin
                  vcnt_nxt = vcnt_q - CNT_ONE;
               end else begin
                  case (v_st_q)
                     V_SYNC:  v_nxt = V_BP;
                     V_BP:    v_nxt = V_ACT;
                     V_ACT:   v_nxt = V_FP;
                     default: v_nxt = V_SYNC;
                  endcase
                  vcnt_nxt = seg_len(v_nxt, vsync_e, vbp_e, vact_e, vfp_e);
               end
            end
         end
      end
   end

   always_comb begin
      divcnt_nxt = '0;
      if (en_i && (divcnt_q < div_e)) divcnt_nxt = divcnt_q + DIV_ONE;
   end

   assign nxt_act     = (h_nxt == H_ACT) && (v_nxt == V_ACT);
   assign pix_ready_o = tick & nxt_act & pix_valid_i;
   assign under       = tick & nxt_act & ~pix_valid_i;
   assign underrun_o  = under;
   assign pclk_en_o   = tick;

   // Control registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         divcnt_q <= '0;
         run_q    <= 1'b0;
         en_q     <= 1'b0;
         h_st_q   <= H_SYNC;
         v_st_q   <= V_SYNC;
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         ucnt_q   <= '0;
      end else begin
         divcnt_q <= divcnt_nxt;
         run_q    <= run_nxt;
         en_q     <= en_i;
         h_st_q   <= h_nxt;
         v_st_q   <= v_nxt;
         hcnt_q   <= hcnt_nxt;
         vcnt_q   <= vcnt_nxt;
         if (en_i && !en_q) ucnt_q <= '0;
         else if (under)    ucnt_q <= sat_inc(ucnt_q);
      end
   end

   // Configuration shadow
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         div_sh   <= '0;
         hsync_sh <= '0;
         hbp_sh   <= '0;
         hact_sh  <= '0;
         hfp_sh   <= '0;
         vsync_sh <= '0;
         vbp_sh   <= '0;
         vact_sh  <= '0;
         vfp_sh   <= '0;
         hpol_sh  <= 1'b0;
         vpol_sh  <= 1'b0;
      end else if (load_cfg) begin
         div_sh   <= div_i;
         hsync_sh <= hsync_i;
         hbp_sh   <= hbp_i;
         hact_sh  <= hact_i;
         hfp_sh   <= hfp_i;
         vsync_sh <= vsync_i;
         vbp_sh   <= vbp_i;
         vact_sh  <= vact_i;
         vfp_sh   <= vfp_i;
         hpol_sh  <= hpol_i;
         vpol_sh  <= vpol_i;
      end
   end

   // ---- output stage p1: pixel period that begins at this tick ----
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hsync_p1 <= 1'b0;
         vsync_p1 <= 1'b0;
         de_p1    <= 1'b0;
         rgb_p1   <= '0;
         fs_p1    <= 1'b0;
      end else if (!en_i) begin
         // Idle: syncs rest at the inactive level of the shadowed polarity.
         hsync_p1 <= hpol_sh;
         vsync_p1 <= vpol_sh;
         de_p1    <= 1'b0;
         rgb_p1   <= '0;
         fs_p1    <= 1'b0;
      end else if (tick) begin
         hsync_p1 <= (h_nxt == H_SYNC) ^ hpol_e;
         vsync_p1 <= (v_nxt == V_SYNC) ^ vpol_e;
         de_p1    <= nxt_act;
         rgb_p1   <= (nxt_act && pix_valid_i) ? pix_data_i : '0;
         fs_p1    <= new_frame;
      end else begin
         fs_p1    <= 1'b0;
      end
   end

   assign hsync_o        = hsync_p1;
   assign vsync_o        = vsync_p1;
   assign de_o           = de_p1;
   assign rgb_o          = rgb_p1;
   assign frame_start_o  = fs_p1;
   assign underrun_cnt_o = ucnt_q;

endmodule

// File: tb/tb_vgalcd_tmg_gen.sv
// -----------------------------------------------------------------------------
// tb_vgalcd_tmg_gen
//
// Randomized bench for vgalcd_tmg_gen. A behavioural model tracks the frame
// as a linear pixel index and derives segment, line and column positions
// arithmetically from the shadowed field values.
// -----------------------------------------------------------------------------
module tb_vgalcd_tmg_gen;
   localparam int CW = 12;
   localparam int DW = 24;
   localparam int VW = 8;
   localparam int UW = 10;
   localparam int UMAX = (1 << UW) - 1;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic          rst_n_i, en_i, hpol_i, vpol_i, pix_valid_i;
   logic [VW-1:0] div_i;
   logic [CW-1:0] hf [4];
   logic [CW-1:0] vf [4];
   logic [DW-1:0] pix_data_i;
   logic          pix_ready_o, pclk_en_o, hsync_o, vsync_o, de_o;
   logic          frame_start_o, underrun_o;
   logic [DW-1:0] rgb_o;
   logic [UW-1:0] underrun_cnt_o;

   vgalcd_tmg_gen #(
      .CNT_WIDTH (CW),
      .DATA_WIDTH(DW),
      .DIV_WIDTH (VW),
      .UCNT_WIDTH(UW)
   ) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .en_i          (en_i),
      .div_i         (div_i),
      .hsync_i       (hf[0]),
      .hbp_i         (hf[1]),
      .hact_i        (hf[2]),
      .hfp_i         (hf[3]),
      .vsync_i       (vf[0]),
      .vbp_i         (vf[1]),
      .vact_i        (vf[2]),
      .vfp_i         (vf[3]),
      .hpol_i        (hpol_i),
      .vpol_i        (vpol_i),
      .pix_valid_i   (pix_valid_i),
      .pix_data_i    (pix_data_i),
      .pix_ready_o   (pix_ready_o),
      .pclk_en_o     (pclk_en_o),
      .hsync_o       (hsync_o),
      .vsync_o       (vsync_o),
      .de_o          (de_o),
      .rgb_o         (rgb_o),
      .frame_start_o (frame_start_o),
      .underrun_o    (underrun_o),
      .underrun_cnt_o(underrun_cnt_o)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int vprob = 100;
   int cnt_rdy, cnt_hs, cnt_vs, cnt_de, cnt_fs, cnt_pclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
   endtask

   // ---------------- reference model ----------------
   int          sh_h [4];
   int          sh_v [4];
   int          sh_div;
   bit          sh_hp, sh_vp;
   bit          m_run, m_enq;
   int          m_pos, m_phase;
   bit          e_hs, e_vs, e_de, e_fs;
   logic [DW-1:0] e_rgb;
   int          e_ucnt;
   bit          x_pclk, x_rdy, x_und;

   function automatic int seg_of(input int x, input int f [4]);
      int acc;
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         acc += f[i] + 1;
         if (x < acc) return i;
      end
      return 3;
   endfunction

   function automatic int total_len(input int f [4]);
      return f[0] + f[1] + f[2] + f[3] + 4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         sh_h[i] = 0;
         sh_v[i] = 0;
      end
      sh_div = 0; sh_hp = 0; sh_vp = 0;
      m_run = 0; m_enq = 0; m_pos = 0; m_phase = 0;
      e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_rgb = '0; e_ucnt = 0;
      x_pclk = 0; x_rdy = 0; x_und = 0;
   endtask

   // Predicts this clock's strobes and the registered outputs after the edge.
   task automatic model_step();
      bit tick, nf, act;
      int llen, flen, hs, vs;
      x_pclk = 0; x_rdy = 0; x_und = 0;
      if (!rst_n_i) return;
      tick = en_i && (m_phase == 0);
      if (!en_i) begin
         m_run = 0; m_pos = 0; m_phase = 0;
         e_hs = sh_hp; e_vs = sh_vp; e_de = 0; e_rgb = '0; e_fs = 0;
      end else if (tick) begin
         flen = total_len(sh_v) * total_len(sh_h);
         nf = !m_run || (m_pos == flen - 1);
         if (nf) begin
            for (int i = 0; i < 4; i++) begin
               sh_h[i] = int'(hf[i]);
               sh_v[i] = int'(vf[i]);
            end
            sh_div = int'(div_i); sh_hp = hpol_i; sh_vp = vpol_i;
            m_pos = 0;
         end else begin
            m_pos++;
         end
         m_run = 1;
         llen = total_len(sh_h);
         hs = seg_of(m_pos % llen, sh_h);
         vs = seg_of(m_pos / llen, sh_v);
         act = (hs == 2) && (vs == 2);
         x_pclk = 1;
         x_rdy = act && pix_valid_i;
         x_und = act && !pix_valid_i;
         e_hs = (hs == 0) ^ sh_hp;
         e_vs = (vs == 0) ^ sh_vp;
         e_de = act;
         e_rgb = x_rdy ? pix_data_i : '0;
         e_fs = nf;
         m_phase = (sh_div == 0) ? 0 : 1;
      end else begin
         e_fs = 0;
         m_phase = (m_phase + 1) % (sh_div + 1);
      end
      if (en_i && !m_enq) e_ucnt = 0;
      else if (x_und && e_ucnt < UMAX) e_ucnt++;
      m_enq = en_i;
   endtask

   // One clock: check registered outputs, drive pixel inputs, check strobes.
   task automatic cycle();
      @(negedge clk_i);
      cyc++;
      chk("hsync", 64'(hsync_o), 64'(e_hs));
      chk("vsync", 64'(vsync_o), 64'(e_vs));
      chk("de", 64'(de_o), 64'(e_de));
      chk("rgb", 64'(rgb_o), 64'(e_rgb));
      chk("frame_start", 64'(frame_start_o), 64'(e_fs));
      chk("underrun_cnt", 64'(underrun_cnt_o), 64'(e_ucnt));
      cnt_hs += int'(hsync_o); cnt_vs += int'(vsync_o);
      cnt_de += int'(de_o);    cnt_fs += int'(frame_start_o);
      pix_valid_i = ($urandom_range(99) < vprob);
      pix_data_i  = DW'($urandom);
      #1;
      model_step();
      chk("pclk_en", 64'(pclk_en_o), 64'(x_pclk));
      chk("pix_ready", 64'(pix_ready_o), 64'(x_rdy));
      chk("underrun", 64'(underrun_o), 64'(x_und));
      cnt_rdy += int'(pix_ready_o); cnt_pclk += int'(pclk_en_o);
      @(posedge clk_i);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clr_cnt();
      cnt_rdy = 0; cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0; cnt_pclk = 0;
   endtask

   task automatic set_cfg(input int h0, h1, h2, h3, v0, v1, v2, v3, d,
                          input bit hp, vp);
      hf[0] = CW'(h0); hf[1] = CW'(h1); hf[2] = CW'(h2); hf[3] = CW'(h3);
      vf[0] = CW'(v0); vf[1] = CW'(v1); vf[2] = CW'(v2); vf[3] = CW'(v3);
      div_i = VW'(d); hpol_i = hp; vpol_i = vp;
   endtask

   task automatic async_reset();
      rst_n_i = 1'b0;
      #1;
      chk("rst_hsync", 64'(hsync_o), 64'd0);
      chk("rst_vsync", 64'(vsync_o), 64'd0);
      chk("rst_de", 64'(de_o), 64'd0);
      chk("rst_rgb", 64'(rgb_o), 64'd0);
      chk("rst_fs", 64'(frame_start_o), 64'd0);
      chk("rst_ucnt", 64'(underrun_cnt_o), 64'd0);
      chk("rst_pclk", 64'(pclk_en_o), 64'd0);
      chk("rst_ready", 64'(pix_ready_o), 64'd0);
      chk("rst_under", 64'(underrun_o), 64'd0);
      model_reset();
      run(2);
      rst_n_i = 1'b1;
   endtask

   initial begin
      rst_n_i = 1'b0; en_i = 1'b0; pix_valid_i = 1'b0; pix_data_i = '0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      clr_cnt();
      run(3);
      rst_n_i = 1'b1;
      run(2);

      // Basic frame: 8-clock lines, 40-clock frame
      set_cfg(1, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0);
      vprob = 100;
      en_i = 1'b1;
      clr_cnt();
      run(40);
      chk("basic_pixels", 64'(cnt_rdy), 64'd8);
      chk("basic_hsync_clks", 64'(cnt_hs), 64'd10);
      chk("basic_vsync_clks", 64'(cnt_vs), 64'd8);
      chk("basic_de_clks", 64'(cnt_de), 64'd8);
      clr_cnt();
      run(40);
      chk("basic_fs_per_40", 64'(cnt_fs), 64'd1);

      // Divider and polarity
      en_i = 1'b0;
      run(3);
      set_cfg(1, 0, 3, 0, 0, 0, 1, 0, 2, 1, 1);
      en_i = 1'b1;
      clr_cnt();
      run(24);
      chk("div_ticks_per_line", 64'(cnt_pclk), 64'd8);
      run(130);

      // Underrun with random FIFO gaps
      vprob = 70;
      run(200);

      // Shadowing: hact changes mid-frame
      en_i = 1'b0;
      run(2);
      set_cfg(1, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0);
      vprob = 100;
      en_i = 1'b1;
      run(17);
      hf[2] = CW'(7);
      run(120);

      // Disable mid-frame, then re-enable
      vprob = 60;
      run(27);
      en_i = 1'b0;
      run(2);
      en_i = 1'b1;
      run(60);

      // Asynchronous reset while active
      run(19);
      async_reset();
      run(60);

      // Randomized configurations
      for (int it = 0; it < 12; it++) begin
         set_cfg($urandom_range(5), $urandom_range(5), $urandom_range(5), $urandom_range(5),
                 $urandom_range(3), $urandom_range(3), $urandom_range(4), $urandom_range(3),
                 $urandom_range(3), 1'($urandom), 1'($urandom));
         vprob = 50 + $urandom_range(50);
         if ($urandom_range(3) == 0) begin
            en_i = 1'b0;
            run(1 + $urandom_range(3));
            en_i = 1'b1;
         end
         run(50 + $urandom_range(250));
      end

      // Continuous underrun until the counter saturates
      en_i = 1'b0;
      run(2);
      set_cfg(0, 0, 63, 0, 0, 0, 15, 0, 0, 0, 0);
      vprob = 0;
      en_i = 1'b1;
      run(1400);
      chk("ucnt_saturated", 64'(underrun_cnt_o), 64'(UMAX));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
